hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage MIPS core. Sits in ID alongside the EX-stage forwarding logic, and drives the PC and pipeline-register enables and flushes. It detects load-use hazards that forwarding cannot cover, flushes on taken branches, and sequences the multi-cycle multiply/divide unit. While that unit runs, it holds back any HI/LO consumer.

---
 rtl/hazard_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for the 5-stage MIPS core (ID stage).
//
// Detects load-use hazards that EX forwarding cannot cover, flushes IF/ID and
// ID/EX on a taken branch/jump, and sequences the multi-cycle MULT/DIV unit.
// While that unit is busy, any HI/LO consumer in ID is held back.
//
// Optional build macro: HAZARD_STATS_EN adds a saturating 32-bit stall counter
// (StallCnt) that counts every clock on which PCWrite is low.
//
// Ports:
//   clk, rst_n          core clock (rising edge), async active-low reset
//   Rs_ID, Rt_ID        source fields of the instruction in ID
//   UseRt_ID            ID instruction actually reads rt
//   MemRead_EX          EX instruction is a load
//   RegWtaddr_EX        EX destination register
//   BranchTaken_EX      branch/jump in EX resolved taken
//   MulStart_EX         MULT/MULTU in EX this cycle
//   DivStart_EX         DIV/DIVU in EX this cycle
//   MdUse_ID            ID instruction reads HI/LO or is itself an MD op
//   PCWrite, IFIDWrite  PC / IF-ID enables
//   IFIDFlush           clear IF/ID to NOP
//   IDEXFlush           clear ID/EX to NOP (bubble)
//   MdBusy              MD unit occupied
//   MdDone              one-cycle pulse on the final MD cycle
//   MdState             debug view of the MD FSM state (0 IDLE, 1 MUL, 2 DIV)
//   StallCnt            (HAZARD_STATS_EN only) saturating stall-cycle count
//
// No handshakes here: every input is a per-cycle level from the pipeline and
// every output is a per-cycle level consumed by the pipeline registers.

module hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  Rs_ID,
  input  logic [4:0]  Rt_ID,
  input  logic        UseRt_ID,
  input  logic        MemRead_EX,
  input  logic [4:0]  RegWtaddr_EX,
  input  logic        BranchTaken_EX,
  input  logic        MulStart_EX,
  input  logic        DivStart_EX,
  input  logic        MdUse_ID,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IFIDFlush,
  output logic        IDEXFlush,
  output logic        MdBusy,
  output logic        MdDone,
  output logic [1:0]  MdState
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] StallCnt
`endif
);

  localparam int CW = $clog2(DIV_CYCLES) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_t;

  md_state_t         r_state;
  md_state_t         w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_lu;
  logic              w_mh;
  logic              w_md_active;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic. The start cycle itself is the first occupied cycle, so
  // the counter loads N-1 and the FSM spends N-1 cycles in MUL/DIV.
  // Starts arriving outside IDLE are ignored (MH keeps them out of EX).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (DivStart_EX) begin
          w_state_nxt = ST_DIV;
          w_cnt_nxt   = CW'(DIV_CYCLES - 1);
        end else if (MulStart_EX) begin
          w_state_nxt = ST_MUL;
          w_cnt_nxt   = CW'(MUL_CYCLES - 1);
        end
      end
      ST_MUL, ST_DIV: begin
        if (r_cnt == CW'(1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_md_active = (r_state != ST_IDLE);
  assign MdDone      = w_md_active && (r_cnt == CW'(1));
  // Busy also covers the cycle the MD op sits in EX, so an HI/LO consumer
  // directly behind it is held.
  assign MdBusy      = w_md_active || MulStart_EX || DivStart_EX;
  assign MdState     = r_state;

  assign w_lu = MemRead_EX && (RegWtaddr_EX != 5'd0) &&
                ((RegWtaddr_EX == Rs_ID) || (UseRt_ID && (RegWtaddr_EX == Rt_ID)));
  // On the done cycle the result is being written back, so the consumer may go.
  assign w_mh = MdUse_ID && MdBusy && !MdDone;

  // Pipeline control; a taken branch overrides stalls since ID is wrong-path.
  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b0;
    if (BranchTaken_EX) begin
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else if (w_lu || w_mh) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXFlush = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (!PCWrite && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign StallCnt = r_stall_cnt;
`endif

endmodule
